// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and widths.
package pulse_stretcher_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    GAP  = 2'b10
  } state_t;

endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// Up/down counter that saturates at both ends; simultaneous inc and dec hold.
module pulse_stretcher_sat_counter
  import pulse_stretcher_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full
);

  assign full = &count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle trig pulses into len-cycle high windows on z, each
// followed by a forced low gap; triggers arriving while busy are queued.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int PEND_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [CNT_W-1:0]  len,
  output logic              z,
  output logic              busy,
  output logic              done,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GCNT_W-1:0] GAP_LOAD = GCNT_W'(GAP_CYCLES - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  hcnt, hcnt_next, hcnt_load;
  logic [GCNT_W-1:0] gcnt, gcnt_next;
  logic              gap_exit, pend_nz, pend_full, inc, dec;

  // A zero length still produces a one-cycle window.
  assign hcnt_load = (len == '0) ? '0 : len - CNT_W'(1);
  assign pend_nz   = (pend != '0);
  assign gap_exit  = (state == GAP) && (gcnt == '0);

  // A GAP-exit launch takes from the queue first; a trig consumed directly is not queued.
  assign dec = gap_exit && pend_nz;
  assign inc = trig && (state != IDLE) && !(gap_exit && !pend_nz);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_next = state;
    hcnt_next  = hcnt;
    gcnt_next  = gcnt;
    case (state)
      IDLE: begin
        if (trig) begin
          state_next = HIGH;
          hcnt_next  = hcnt_load;
        end
      end
      HIGH: begin
        if (hcnt != '0) begin
          hcnt_next = hcnt - CNT_W'(1);
        end else begin
          state_next = GAP;
          gcnt_next  = GAP_LOAD;
        end
      end
      GAP: begin
        if (gcnt != '0) begin
          gcnt_next = gcnt - GCNT_W'(1);
        end else if (pend_nz || trig) begin
          state_next = HIGH;
          hcnt_next  = hcnt_load;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= '0;
      gcnt  <= '0;
      z     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      hcnt  <= hcnt_next;
      gcnt  <= gcnt_next;
      z     <= (state_next == HIGH);
      busy  <= (state_next != IDLE);
      done  <= (state == HIGH) && (hcnt == '0);
      ovf   <= inc && pend_full && !dec;
    end
  end

  pulse_stretcher_sat_counter #(
    .W (PEND_W)
  ) u_pend (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .count (pend),
    .full  (pend_full)
  );

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed and randomized scenario tests for pulse_stretcher with inline checks.
module tb_pulse_stretcher;

  localparam int CNT_W      = 8;
  localparam int GAP_CYCLES = 2;
  localparam int PEND_W     = 2;

  logic              clk  = 1'b0;
  logic              rst  = 1'b1;
  logic              trig = 1'b0;
  logic [CNT_W-1:0]  len  = '0;
  logic              z, busy, done, ovf;
  logic [PEND_W-1:0] pend;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .CNT_W      (CNT_W),
    .GAP_CYCLES (GAP_CYCLES),
    .PEND_W     (PEND_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .trig (trig),
    .len  (len),
    .z    (z),
    .busy (busy),
    .done (done),
    .pend (pend),
    .ovf  (ovf)
  );

  // Drive trig for one edge, then sample outputs 1 time unit after that edge.
  task automatic tick(input logic t);
    trig = t;
    @(posedge clk);
    #1;
    trig = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({z, busy, done, ovf, pend} !== '0) begin
      failures++;
      $display("FAIL reset_state z=%b busy=%b done=%b ovf=%b pend=%0d expected all 0",
               z, busy, done, ovf, pend);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_len3(input string tag);
    bit tv [6] = '{1, 0, 0, 0, 0, 0};
    bit ez [6] = '{1, 1, 1, 0, 0, 0};
    bit ed [6] = '{0, 0, 0, 1, 0, 0};
    bit eb [6] = '{1, 1, 1, 1, 1, 0};
    len = 8'd3;
    for (int i = 0; i < 6; i++) begin
      tick(tv[i]);
      checks++;
      if ({z, done, busy} !== {ez[i], ed[i], eb[i]}) begin
        failures++;
        $display("FAIL %s step%0d z/done/busy=%b%b%b expected %b%b%b",
                 tag, i, z, done, busy, ez[i], ed[i], eb[i]);
      end
    end
  endtask

  task automatic test_len0();
    bit tv [4] = '{1, 0, 0, 0};
    bit ez [4] = '{1, 0, 0, 0};
    bit ed [4] = '{0, 1, 0, 0};
    bit eb [4] = '{1, 1, 1, 0};
    len = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick(tv[i]);
      checks++;
      if ({z, done, busy} !== {ez[i], ed[i], eb[i]}) begin
        failures++;
        $display("FAIL len0 step%0d z/done/busy=%b%b%b expected %b%b%b",
                 i, z, done, busy, ez[i], ed[i], eb[i]);
      end
    end
  endtask

  task automatic test_queue();
    bit tv [9] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    bit ez [9] = '{1, 1, 0, 0, 1, 1, 0, 0, 0};
    bit ed [9] = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
    bit eb [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    int ep [9] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
    len = 8'd2;
    for (int i = 0; i < 9; i++) begin
      tick(tv[i]);
      checks++;
      if ({z, done, busy} !== {ez[i], ed[i], eb[i]} || int'(pend) != ep[i]) begin
        failures++;
        $display("FAIL queue step%0d z/done/busy=%b%b%b pend=%0d expected %b%b%b pend=%0d",
                 i, z, done, busy, pend, ez[i], ed[i], eb[i], ep[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bit tv [6] = '{1, 1, 1, 1, 1, 0};
    bit ez [6] = '{1, 1, 1, 1, 0, 0};
    bit eo [6] = '{0, 0, 0, 0, 1, 0};
    int ep [6] = '{0, 1, 2, 3, 3, 3};
    int rises = 1;
    int extra_ovf = 0;
    int cyc = 0;
    logic prev_z;
    len = 8'd4;
    for (int i = 0; i < 6; i++) begin
      tick(tv[i]);
      checks++;
      if (z !== ez[i] || ovf !== eo[i] || int'(pend) != ep[i]) begin
        failures++;
        $display("FAIL overflow step%0d z=%b ovf=%b pend=%0d expected z=%b ovf=%b pend=%0d",
                 i, z, ovf, pend, ez[i], eo[i], ep[i]);
      end
    end
    prev_z = z;
    while (busy && cyc < 200) begin
      tick(1'b0);
      cyc++;
      if (z && !prev_z) rises++;
      if (ovf) extra_ovf++;
      prev_z = z;
    end
    checks++;
    if (rises != 4 || extra_ovf != 0 || pend !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL overflow_drain windows=%0d late_ovf=%0d pend=%0d busy=%b expected 4 0 0 0",
               rises, extra_ovf, pend, busy);
    end
  endtask

  task automatic test_gap_exit_direct();
    bit tv [7] = '{1, 0, 0, 1, 0, 0, 0};
    bit ez [7] = '{1, 0, 0, 1, 0, 0, 0};
    bit eb [7] = '{1, 1, 1, 1, 1, 1, 0};
    len = 8'd1;
    for (int i = 0; i < 7; i++) begin
      tick(tv[i]);
      checks++;
      if ({z, busy} !== {ez[i], eb[i]} || pend !== '0 || ovf !== 1'b0) begin
        failures++;
        $display("FAIL gap_exit_direct step%0d z/busy=%b%b pend=%0d ovf=%b expected %b%b pend=0 ovf=0",
                 i, z, busy, pend, ovf, ez[i], eb[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit tv [10] = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    bit ez [10] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    bit eb [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int ep [10] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    len = 8'd1;
    for (int i = 0; i < 10; i++) begin
      tick(tv[i]);
      checks++;
      if ({z, busy} !== {ez[i], eb[i]} || int'(pend) != ep[i] || ovf !== 1'b0) begin
        failures++;
        $display("FAIL back_to_back step%0d z/busy=%b%b pend=%0d ovf=%b expected %b%b pend=%0d ovf=0",
                 i, z, busy, pend, ovf, ez[i], eb[i], ep[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    len = 8'd5;
    tick(1'b1);
    tick(1'b1);
    checks++;
    if (z !== 1'b1 || busy !== 1'b1 || pend !== PEND_W'(1)) begin
      failures++;
      $display("FAIL pre_reset z=%b busy=%b pend=%0d expected 1 1 1", z, busy, pend);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({z, busy, done, ovf, pend} !== '0) begin
      failures++;
      $display("FAIL async_reset z=%b busy=%b done=%b ovf=%b pend=%0d expected all 0",
               z, busy, done, ovf, pend);
    end
    #2;
    rst = 1'b0;
    tick(1'b0);
    checks++;
    if ({z, busy, pend} !== '0) begin
      failures++;
      $display("FAIL post_reset_idle z=%b busy=%b pend=%0d expected all 0", z, busy, pend);
    end
    test_len3("after_reset");
  endtask

  task automatic test_random();
    int   trigs = 0, ovfs = 0, rises = 0, dones = 0, short_gaps = 0;
    int   low_run = 0, cyc = 0;
    logic prev_z = 1'b0;
    logic t;
    for (int i = 0; i < 400 + 2000; i++) begin
      if (i >= 400 && !busy && pend == '0) break;
      t = (i < 400) && ($urandom_range(0, 2) == 0);
      len = CNT_W'($urandom_range(0, 5));
      tick(t);
      cyc++;
      if (t) trigs++;
      if (ovf) ovfs++;
      if (done) dones++;
      if (z && !prev_z) begin
        if (rises > 0 && low_run < GAP_CYCLES) short_gaps++;
        rises++;
      end
      low_run = z ? 0 : low_run + 1;
      prev_z = z;
    end
    checks++;
    if (busy !== 1'b0 || pend !== '0) begin
      failures++;
      $display("FAIL random_drain busy=%b pend=%0d after %0d cycles expected idle", busy, pend, cyc);
    end
    checks++;
    if (rises != trigs - ovfs) begin
      failures++;
      $display("FAIL random_edges edges=%0d expected %0d (trigs=%0d ovf=%0d)",
               rises, trigs - ovfs, trigs, ovfs);
    end
    checks++;
    if (short_gaps != 0) begin
      failures++;
      $display("FAIL random_gaps short_gaps=%0d expected 0", short_gaps);
    end
    checks++;
    if (dones != rises) begin
      failures++;
      $display("FAIL random_done done_pulses=%0d expected %0d", dones, rises);
    end
  endtask

  initial begin
    test_reset();
    test_len3("single");
    test_len0();
    test_queue();
    test_overflow();
    test_gap_exit_direct();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
